led_pwm_driver: RTL

Downstream consumer of the LED peripheral register. It takes the 16-bit LED pattern held by that register and drives the 16 board LEDs. On the way it applies global 4-bit PWM dimming and an optional blink. Pattern and brightness are re-sampled only at PWM frame boundaries, so software writes never produce a truncated PWM pulse.

---
 rtl/led_pkg.sv | 21 ++
 rtl/led_pwm_driver_tick_gen.sv | 29 ++
 rtl/led_pwm_driver.sv | 106 ++++++++++
 3 files changed

// File: rtl/led_pkg.sv
// Shared constants, the blink phase type and parameter-derived divider helpers
// for the LED PWM driver.
package led_pkg;

    localparam int unsigned PWM_BITS = 4;
    localparam int unsigned LED_W    = 16;
    localparam int unsigned SLOTS    = 1 << PWM_BITS;

    typedef enum logic {PH_ON, PH_OFF} blink_phase_t;

    // Clock cycles per PWM slot.
    function automatic int unsigned calc_presc(input int unsigned clk_hz, input int unsigned pwm_hz);
        return clk_hz / (pwm_hz * SLOTS);
    endfunction

    // PWM frames per blink half-period.
    function automatic int unsigned calc_half(input int unsigned pwm_hz, input int unsigned blink_hz);
        return pwm_hz / (2 * blink_hz);
    endfunction

endpackage

// File: rtl/led_pwm_driver_tick_gen.sv
// Free-running prescaler; tick is high for the one cycle in which the count
// has just wrapped back to zero.
module tick_gen #(
    parameter int unsigned DIV = 625
) (
    input  logic clk_i,
    input  logic reset_i,
    output logic tick
);

    localparam int unsigned    CW   = $clog2(DIV);
    localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == LAST) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= CW'(cnt + 1);
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/led_pwm_driver.sv
// Drives 16 LEDs from the LED register with global 4-bit PWM dimming and an
// optional blink; pattern, brightness and blink enable are sampled per frame.
module led_pwm_driver
    import led_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 10_000_000,
    parameter int unsigned PWM_HZ   = 1000,
    parameter int unsigned BLINK_HZ = 2
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [LED_W-1:0]    leds_reg_i,
    input  logic [PWM_BITS-1:0] brightness_i,
    input  logic                blink_en_i,
    output logic [LED_W-1:0]    leds_o,
    output logic                frame_o
);

    localparam int unsigned   PRESC      = calc_presc(CLK_HZ, PWM_HZ);
    localparam int unsigned   HALF       = calc_half(PWM_HZ, BLINK_HZ);
    localparam int unsigned   FW         = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(HALF - 1);

    if (PRESC < 2) begin : g_presc_chk
        $error("led_pwm_driver: PRESC must be at least 2");
    end
    if (HALF < 1) begin : g_half_chk
        $error("led_pwm_driver: HALF must be at least 1");
    end

    logic                tick;
    logic                first_q;
    logic                blink_q;
    logic [PWM_BITS-1:0] pwm_cnt,    pwm_n;
    logic [FW-1:0]       frame_cnt,  fcnt_n;
    logic [LED_W-1:0]    shadow_pat, pat_n;
    logic [PWM_BITS-1:0] shadow_bri, bri_n;
    blink_phase_t        phase,      phase_n;
    logic                blink_n;
    logic                boundary;
    logic                led_on;
    logic [LED_W-1:0]    leds_n;

    tick_gen #(.DIV(PRESC)) u_tick_gen (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .tick    (tick)
    );

    assign boundary = reset_i & (first_q | (tick & (pwm_cnt == '1)));
    assign frame_o  = boundary;

    // Outputs are computed from next-state values so a pattern captured at a
    // boundary shows up on leds_o in the very next cycle.
    always_comb begin
        pwm_n   = tick ? pwm_cnt + 4'd1 : pwm_cnt;
        pat_n   = shadow_pat;
        bri_n   = shadow_bri;
        phase_n = phase;
        fcnt_n  = frame_cnt;
        blink_n = blink_q;
        if (boundary) begin
            pat_n   = leds_reg_i;
            bri_n   = brightness_i;
            blink_n = blink_en_i;
            if (!blink_en_i) begin
                fcnt_n  = '0;
                phase_n = PH_ON;
            end else if (blink_q) begin
                // Only frames that were themselves blink frames advance the
                // count, so the first blink frame is ON frame 0.
                if (frame_cnt == FRAME_LAST) begin
                    fcnt_n  = '0;
                    phase_n = (phase == PH_ON) ? PH_OFF : PH_ON;
                end else begin
                    fcnt_n = FW'(frame_cnt + 1);
                end
            end
        end
        led_on = ((bri_n == '1) || (pwm_n < bri_n)) && (phase_n == PH_ON);
        leds_n = pat_n & {LED_W{led_on}};
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            first_q    <= 1'b1;
            blink_q    <= 1'b0;
            pwm_cnt    <= '0;
            frame_cnt  <= '0;
            shadow_pat <= '0;
            shadow_bri <= '0;
            phase      <= PH_ON;
            leds_o     <= '0;
        end else begin
            first_q    <= 1'b0;
            blink_q    <= blink_n;
            pwm_cnt    <= pwm_n;
            frame_cnt  <= fcnt_n;
            shadow_pat <= pat_n;
            shadow_bri <= bri_n;
            phase      <= phase_n;
            leds_o     <= leds_n;
        end
    end

endmodule
